// File: rtl/polar_encoder_iter.sv
// Iterative polar encoder: x = u * G_N for N = 8..256, one butterfly stage per clock.
// Optional build macro POLAR_ENC_FROZEN_MASK_EN adds a frozen_mask input applied on accept.
module polar_encoder_iter #(
  parameter int N_MAX_LOG2 = 8,
  parameter int LEN_SEL_W  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [(1<<N_MAX_LOG2)-1:0]   u_in,
`ifdef POLAR_ENC_FROZEN_MASK_EN
  input  logic [(1<<N_MAX_LOG2)-1:0]   frozen_mask,
`endif
  input  logic [LEN_SEL_W-1:0]         len_sel,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [(1<<N_MAX_LOG2)-1:0]   x_out,
  output logic                         busy
);

  localparam int unsigned W  = 1 << N_MAX_LOG2;
  localparam int unsigned CW = (N_MAX_LOG2 > 1) ? $clog2(N_MAX_LOG2) : 1;
  localparam int unsigned SW = $clog2(N_MAX_LOG2 + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] stages_q, stages_d;
  logic [W-1:0]  work_q, work_d;

  logic [N_MAX_LOG2-1:0][W-1:0] stage_net;
  logic [W-1:0]  stage_out;
  logic [W-1:0]  len_mask;
  logic [W-1:0]  u_eff;
  logic [SW-1:0] stages_new;

  // One fixed XOR network per stage: bit i takes bit i-h when bit c of i is set.
  for (genvar c = 0; c < N_MAX_LOG2; c++) begin : g_stage
    for (genvar i = 0; i < W; i++) begin : g_bit
      if (((i >> c) & 1) != 0) begin : g_xor
        assign stage_net[c][i] = work_q[i] ^ work_q[i - (1 << c)];
      end else begin : g_pass
        assign stage_net[c][i] = work_q[i];
      end
    end
  end

  assign stage_out = stage_net[cnt_q];

  always_comb begin
    if (len_sel > LEN_SEL_W'(N_MAX_LOG2 - 3)) begin
      stages_new = SW'(N_MAX_LOG2);
    end else begin
      stages_new = SW'(len_sel) + SW'(3);
    end
  end

  // Bit i lies inside the code when its index needs no more than S address bits.
  for (genvar i = 0; i < W; i++) begin : g_len
    localparam int unsigned NEED = $clog2(i + 1);
    assign len_mask[i] = (stages_new >= SW'(NEED));
  end

`ifdef POLAR_ENC_FROZEN_MASK_EN
  assign u_eff = u_in & ~frozen_mask & len_mask;
`else
  assign u_eff = u_in & len_mask;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stages_d = stages_q;
    work_d   = work_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          stages_d = stages_new;
          work_d   = u_eff;
          cnt_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        work_d = stage_out;
        cnt_d  = cnt_q + CW'(1);
        if ((SW'(cnt_q) + SW'(1)) == stages_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      stages_q <= '0;
      work_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stages_q <= stages_d;
      work_q   <= work_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign x_out     = work_q;

endmodule
